// File: rtl/exp2_logic_pipe.sv
//==============================================================================
// Module   : exp2_logic_pipe
// Purpose  : Two-stage valid/ready pipeline that applies a mode-selected
//            bitwise operator, counts result ones and counts all-ones results.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module exp2_logic_pipe #(
    parameter  int WIDTH  = 8,
    parameter  int CNT_W  = 16,
    localparam int ONES_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [WIDTH-1:0]  c,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  z,
    output logic [ONES_W-1:0] z_ones,
    output logic [CNT_W-1:0]  match_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};

    logic              r_s1_valid;
    logic [WIDTH-1:0]  r_s1_a;
    logic [WIDTH-1:0]  r_s1_b;
    logic [WIDTH-1:0]  r_s1_c;
    logic [1:0]        r_s1_mode;
    logic              r_s2_valid;
    logic [WIDTH-1:0]  r_z;
    logic [ONES_W-1:0] r_z_ones;
    logic [CNT_W-1:0]  r_match_cnt;

    logic              w_s2_load;
    logic              w_s1_load;
    logic              w_out_xfer;
    logic [WIDTH-1:0]  w_z;
    logic [ONES_W-1:0] w_ones;

    function automatic logic [ONES_W-1:0] f_popcount(input logic [WIDTH-1:0] v);
        logic [ONES_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + ONES_W'(v[i]);
        end
        return n;
    endfunction

    // Ready ripples backward combinationally so a full pipe keeps streaming.
    assign w_out_xfer = r_s2_valid && out_ready;
    assign w_s2_load  = !r_s2_valid || out_ready;
    assign w_s1_load  = !r_s1_valid || w_s2_load;
    assign in_ready   = rst_n && w_s1_load;

    always_comb begin
        w_z = '0;
        case (r_s1_mode)
            2'b00:   w_z = r_s1_a & (r_s1_b | r_s1_c);
            2'b01:   w_z = r_s1_a | (r_s1_b & r_s1_c);
            2'b10:   w_z = r_s1_a ^ (r_s1_b | r_s1_c);
            default: w_z = ~(r_s1_a & (r_s1_b | r_s1_c));
        endcase
        w_ones = f_popcount(w_z);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_c      <= '0;
            r_s1_mode   <= '0;
            r_s2_valid  <= 1'b0;
            r_z         <= '0;
            r_z_ones    <= '0;
            r_match_cnt <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_z      <= w_z;
                    r_z_ones <= w_ones;
                end
            end
            if (w_s1_load) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_a    <= a;
                    r_s1_b    <= b;
                    r_s1_c    <= c;
                    r_s1_mode <= mode;
                end
            end
            if (w_out_xfer && (r_z == c_ALL_ONES) && (r_match_cnt != c_CNT_MAX)) begin
                r_match_cnt <= r_match_cnt + 1'b1;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign z         = r_z;
    assign z_ones    = r_z_ones;
    assign match_cnt = r_match_cnt;

endmodule

`default_nettype wire

// File: tb/tb_exp2_logic_pipe.sv
//==============================================================================
// Module   : tb_exp2_logic_pipe
// Purpose  : Directed table-driven bench for exp2_logic_pipe (WIDTH=8, CNT_W=2).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_exp2_logic_pipe;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;
    localparam int NV    = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b, c;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic [3:0]       z_ones;
    logic [CNT_W-1:0] match_cnt;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [1:0] mode;
        logic [7:0] z;
        logic [3:0] ones;
    } vec_t;

    vec_t vecs [NV];
    int   n_pass  = 0;
    int   n_total = 0;
    int   exp_cnt;
    int   sat_exp [4];

    exp2_logic_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .z_ones    (z_ones),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input vec_t t);
        in_valid = v;
        a        = t.a;
        b        = t.b;
        c        = t.c;
        mode     = t.mode;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("in_ready_in_reset", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_release", 32'(in_ready), 32'd1);
    endtask

    initial begin
        //          a      b      c      mode   z      ones
        vecs[0] = '{8'hF0, 8'h0C, 8'h30, 2'b00, 8'h30, 4'd2};
        vecs[1] = '{8'hF0, 8'h0C, 8'h30, 2'b01, 8'hF0, 4'd4};
        vecs[2] = '{8'hF0, 8'h0C, 8'h30, 2'b10, 8'hCC, 4'd4};
        vecs[3] = '{8'hF0, 8'h0C, 8'h30, 2'b11, 8'hCF, 4'd6};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 2'b00, 8'hFF, 4'd8};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 2'b11, 8'hFF, 4'd8};
        vecs[6] = '{8'hAA, 8'h55, 8'h0F, 2'b10, 8'hF5, 4'd6};
        vecs[7] = '{8'h3C, 8'hF0, 8'h0F, 2'b01, 8'h3C, 4'd4};
        vecs[8] = '{8'h81, 8'hFF, 8'hFF, 2'b01, 8'hFF, 4'd8};
        vecs[9] = '{8'hFF, 8'h01, 8'h80, 2'b11, 8'h7E, 4'd6};
        sat_exp = '{1, 2, 3, 3};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; c = '0; mode = '0;

        // Reset values
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_z_ones", 32'(z_ones), 32'd0);
        chk("rst_match_cnt", 32'(match_cnt), 32'd0);
        do_reset();

        // Back-to-back stream: latency 2, one result per cycle
        exp_cnt = 0;
        for (int i = 0; i <= NV + 1; i++) begin
            if (i < NV) drive(1'b1, vecs[i]);
            else        drive(1'b0, vecs[0]);
            tick();
            chk("stream_match_cnt", 32'(match_cnt), 32'(exp_cnt));
            if (i == 0 || i == NV + 1) begin
                chk("stream_idle_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("stream_valid", 32'(out_valid), 32'd1);
                chk("stream_z", 32'(z), 32'(vecs[i-1].z));
                chk("stream_ones", 32'(z_ones), 32'(vecs[i-1].ones));
                if (vecs[i-1].z == 8'hFF && exp_cnt < 3) exp_cnt++;
            end
        end

        // Backpressure: two beats fill the pipe, third waits
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, vecs[0]);
        #1 chk("bp_ready0", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, vecs[1]);
        chk("bp_ready1", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, vecs[2]);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_z", 32'(z), 32'(vecs[0].z));
            chk("bp_hold_ones", 32'(z_ones), 32'(vecs[0].ones));
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, vecs[0]);
        chk("bp_out1_z", 32'(z), 32'(vecs[1].z));
        tick();
        chk("bp_out2_valid", 32'(out_valid), 32'd1);
        chk("bp_out2_z", 32'(z), 32'(vecs[2].z));
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Counter saturation at CNT_W=2
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b1, vecs[4]);
            else       drive(1'b0, vecs[4]);
            tick();
            if (i >= 2) chk("sat_match_cnt", 32'(match_cnt), 32'(sat_exp[i-2]));
        end

        // Reset with two beats in flight
        out_ready = 1'b0;
        drive(1'b1, vecs[0]);
        tick();
        drive(1'b1, vecs[4]);
        tick();
        drive(1'b0, vecs[0]);
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_cnt", 32'(match_cnt), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_no_stale", 32'(out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/exp2_logic_pipe.md
EXP2_LOGIC_PIPE -- requirements
Module: exp2_logic_pipe

Interface
REQ-001: Parameter WIDTH, default 8, bit width of operand vectors a, b, c and result z; legal range 1..32.
REQ-002: Parameter CNT_W, default 16, width of match_cnt.
REQ-003: Clocking SHALL be one clock; reset is synchronous and active-low.
REQ-004: clk  input  1  rising-edge clock; all state SHALL update only on this edge.
REQ-005: rst_n  input  1  synchronous active-low reset.
REQ-006: in_valid  input  1  operand beat present.
REQ-007: in_ready  output  1  block accepts beat this cycle.
REQ-008: a, b, c  input  WIDTH each  operand vectors.
REQ-009: mode  input  2  operator select, sampled with the beat.
REQ-010: out_valid  output  1  result beat present.
REQ-011: out_ready  input  1  downstream accepts result.
REQ-012: z  output  WIDTH  registered result.
REQ-013: z_ones  output  $clog2(WIDTH+1)  count of 1 bits in z.
REQ-014: match_cnt  output  CNT_W  number of transferred results with z all ones.

Function
REQ-015: Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-016: Bitwise per-bit operator by mode: 00 z=a&(b|c); 01 z=a|(b&c); 10 z=a^(b|c); 11 z=~(a&(b|c)).
REQ-017: Pipeline SHALL have two register stages: S1 captures a, b, c and mode; S2 captures z and z_ones computed from S1.
REQ-018: With out_ready held high, a beat accepted at edge N SHALL appear on out_valid/z/z_ones after edge N+2 (latency 2).
REQ-019: Full throughput SHALL be one beat per cycle with out_ready high; no bubbles are inserted.
REQ-020: S2 SHALL load when it is empty or its beat is transferring this cycle; S1 SHALL load when it is empty or advancing into S2.
REQ-021: in_ready SHALL equal !S1_valid || (S2 loads this cycle); with out_ready low and both stages full, in_ready SHALL be 0.
REQ-022: While out_valid=1 and out_ready=0, z, z_ones and out_valid SHALL hold stable.
REQ-023: in_valid=0 cycles SHALL create bubbles; no beat SHALL be duplicated or dropped.
REQ-024: a, b, c and mode are ignored when no input transfer occurs.
REQ-025: match_cnt SHALL increment by 1 on each output transfer where z == all ones.
REQ-026: match_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027: Simultaneous input and output transfer on a full pipe SHALL advance both stages in the same edge with no loss.

Reset
REQ-028: When rst_n=0 at an edge, S1_valid, out_valid, z, z_ones and match_cnt SHALL all go to 0.
REQ-029: While rst_n=0, in_ready SHALL be 0.
REQ-030: in_ready SHALL be 1 in the first cycle after rst_n returns high.
REQ-031: Reset mid-operation SHALL discard all in-flight beats; no result from before reset SHALL appear afterward.

Verification
REQ-032: WIDTH=8, a=F0, b=0C, c=30, mode=00, out_ready=1 -> z=30, z_ones=2, out_valid two edges after acceptance.
REQ-033: Same operands, modes 01/10/11 back-to-back -> z=F0/CC/CF, z_ones=4/4/6 on consecutive cycles.
REQ-034: out_ready=0, send 3 beats -> 2 accepted, then in_ready=0; first result held stable; on out_ready=1 all 3 results emerge in order, one per cycle.
REQ-035: CNT_W=2, four transfers of a=FF, b=FF, c=00, mode=00 -> z=FF; match_cnt=1,2,3,3 (saturated).
REQ-036: Assert rst_n=0 with 2 beats in flight -> next edge out_valid=0, match_cnt=0; after release, no stale beat emerges.
